// File: rtl/bram_stream_loader.sv
// bram_stream_loader
// Fill stage for a block-RAM processing engine. It accepts a valid/ready word
// stream and writes the words to consecutive BRAM addresses starting at 0.
// When the load is complete it pulses proc_start and then waits for proc_done.
//
// Optional feature: define BRAM_LOADER_CHECKSUM_EN to build a running
// modulo-2^DATA_W sum of the loaded words. Without it, checksum is tied to 0.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for load_req; write pointer, len and checksum cleared
// S_LOAD  | in_ready high, each accepted word registered onto mem_*
// S_DRAIN | final write is on the bus, input stalled
// S_START | one-cycle proc_start pulse, BRAM port handed to the processor
// S_WAIT  | waiting for proc_done from the processor

module bram_stream_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              mem_own,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              proc_start,
    input  logic              proc_done,
    output logic              busy,
    output logic [ADDR_W:0]   len,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_START,
        S_WAIT
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W:0]     len_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;

    logic                accept;
    logic                last_word;
    logic [ADDR_W-1:0]   ptr_d;
    logic [ADDR_W:0]     len_d;

    // A word is taken only while loading; in_ready is exactly the LOAD decode.
    assign accept    = (state_q == S_LOAD) && in_valid;
    // in_last and the depth limit collapse into one exit condition.
    assign last_word = in_last || (ptr_q == ADDR_W'(DEPTH - 1));
    assign ptr_d     = ptr_q + ADDR_W'(1);
    assign len_d     = len_q + (ADDR_W + 1)'(1);

    // Controller state plus registered BRAM write port, pointer and length.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            len_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    mem_we_q <= 1'b0;
                    if (load_req) begin
                        state_q <= S_LOAD;
                        ptr_q   <= '0;
                        len_q   <= '0;
                    end
                end
                S_LOAD: begin
                    mem_we_q <= accept;
                    if (accept) begin
                        mem_addr_q  <= ptr_q;
                        mem_wdata_q <= in_data;
                        len_q       <= len_d;
                        // Pointer stays put on the final word so it never wraps.
                        if (last_word) begin
                            state_q <= S_DRAIN;
                        end else begin
                            ptr_q <= ptr_d;
                        end
                    end
                end
                S_DRAIN: begin
                    mem_we_q <= 1'b0;
                    state_q  <= S_START;
                end
                S_START: begin
                    mem_we_q <= 1'b0;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    mem_we_q <= 1'b0;
                    if (proc_done) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    mem_we_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

`ifdef BRAM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;

    // Running sum of accepted words; frozen once the load leaves LOAD.
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_q <= '0;
        end else if ((state_q == S_IDLE) && load_req) begin
            checksum_q <= '0;
        end else if (accept) begin
            checksum_q <= checksum_q + in_data;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign in_ready   = (state_q == S_LOAD);
    assign mem_own    = (state_q == S_LOAD) || (state_q == S_DRAIN);
    assign busy       = (state_q != S_IDLE);
    assign proc_start = (state_q == S_START);
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign len        = len_q;

endmodule

// File: tb/tb_bram_stream_loader.sv
// Directed bench for bram_stream_loader. Expected BRAM writes are queued when
// a word is driven and popped by a negedge monitor whenever mem_we is seen.
module tb_bram_stream_loader;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_req;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              mem_own;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              proc_start;
    logic              proc_done;
    logic              busy;
    logic [ADDR_W:0]   len;
    logic [DATA_W-1:0] checksum;

    int errors = 0;
    int checks = 0;

    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    int                       exp_addr;

    bram_stream_loader #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load_req  (load_req),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .mem_own   (mem_own),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .proc_start(proc_start),
        .proc_done (proc_done),
        .busy      (busy),
        .len       (len),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", {24'd0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                logic [ADDR_W+DATA_W-1:0] e;
                e = exp_q.pop_front();
                chk("write_addr", {24'd0, mem_addr}, {24'd0, e[ADDR_W+DATA_W-1:DATA_W]});
                chk("write_data", {16'd0, mem_wdata}, {16'd0, e[DATA_W-1:0]});
            end
        end
    end

    // Drive one word for a single cycle; it is accepted because we are in LOAD.
    task automatic send_word(input logic [DATA_W-1:0] d, input logic last);
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        exp_q.push_back({exp_addr[ADDR_W-1:0], d});
        exp_addr++;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic begin_load();
        load_req = 1'b1;
        exp_addr = 0;
        tick();
        load_req = 1'b0;
    endtask

    // Called in DRAIN: checks the 2-cycle proc_start latency and WAIT entry.
    task automatic finish_load(input string tag, input int exp_len);
        chk({tag, "_drain_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_drain_mem_own"}, {31'd0, mem_own}, 32'd1);
        chk({tag, "_drain_proc_start"}, {31'd0, proc_start}, 32'd0);
        chk({tag, "_len"}, {23'd0, len}, exp_len);
        tick();
        chk({tag, "_start_pulse"}, {31'd0, proc_start}, 32'd1);
        chk({tag, "_start_mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_start_mem_own"}, {31'd0, mem_own}, 32'd0);
        tick();
        chk({tag, "_wait_proc_start"}, {31'd0, proc_start}, 32'd0);
        chk({tag, "_wait_busy"}, {31'd0, busy}, 32'd1);
    endtask

    task automatic release_proc();
        proc_done = 1'b1;
        tick();
        proc_done = 1'b0;
        chk("idle_after_done_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [DATA_W-1:0] exp_sum;
        reset     = 1'b1;
        load_req  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        proc_done = 1'b0;
        exp_addr  = 0;
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_mem_own", {31'd0, mem_own}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_proc_start", {31'd0, proc_start}, 32'd0);
        chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        chk("rst_len", {23'd0, len}, 32'd0);
        chk("rst_checksum", {16'd0, checksum}, 32'd0);
        reset = 1'b0;
        tick();

        // proc_done in IDLE is ignored; in_valid in IDLE is ignored.
        proc_done = 1'b1;
        in_valid  = 1'b1;
        tick();
        proc_done = 1'b0;
        in_valid  = 1'b0;
        chk("idle_done_ignored_busy", {31'd0, busy}, 32'd0);
        chk("idle_in_ready", {31'd0, in_ready}, 32'd0);

        // Full 256-word load, depth limit terminates it.
        begin_load();
        chk("load_mem_own", {31'd0, mem_own}, 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            send_word(DATA_W'(i), 1'b0);
        end
        finish_load("full", 256);

        // load_req in WAIT is ignored, proc_done 10 cycles into WAIT releases.
        load_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("wait_busy", {31'd0, busy}, 32'd1);
            chk("wait_in_ready", {31'd0, in_ready}, 32'd0);
        end
        load_req = 1'b0;
        tick();
        release_proc();
        chk("len_holds_in_idle", {23'd0, len}, 32'd256);

        // Short load with idle gaps; in_last on the fifth word.
        begin_load();
        for (int k = 0; k < 5; k++) begin
            send_word(DATA_W'(16'h0100 + k), k == 4);
            if (k < 4) begin
                tick();
                chk("gap_mem_we", {31'd0, mem_we}, 32'd0);
                chk("gap_in_ready", {31'd0, in_ready}, 32'd1);
            end
        end
        finish_load("short", 5);
        tick();
        release_proc();

        // Checksum load; also confirms the next load restarts at address 0.
        begin_load();
        send_word(16'hFFFF, 1'b0);
        send_word(16'h0002, 1'b1);
`ifdef BRAM_LOADER_CHECKSUM_EN
        exp_sum = 16'h0001;
`else
        exp_sum = 16'h0000;
`endif
        chk("checksum", {16'd0, checksum}, {16'd0, exp_sum});
        finish_load("csum", 2);
        chk("checksum_stable", {16'd0, checksum}, {16'd0, exp_sum});
        release_proc();

        // Reset after 100 accepts, with in_valid still asserted.
        begin_load();
        for (int i = 0; i < 100; i++) begin
            send_word(DATA_W'(16'h2000 + i), 1'b0);
        end
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        reset    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("midrst_mem_we", {31'd0, mem_we}, 32'd0);
            chk("midrst_len", {23'd0, len}, 32'd0);
            chk("midrst_busy", {31'd0, busy}, 32'd0);
            chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
            chk("midrst_proc_start", {31'd0, proc_start}, 32'd0);
            chk("midrst_mem_addr", {24'd0, mem_addr}, 32'd0);
            chk("midrst_mem_own", {31'd0, mem_own}, 32'd0);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("post_rst_proc_start", {31'd0, proc_start}, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // Fresh 3-word load after the reset writes addresses 0..2.
        begin_load();
        send_word(16'hA000, 1'b0);
        send_word(16'hA001, 1'b0);
        send_word(16'hA002, 1'b1);
        finish_load("post_rst", 3);
        release_proc();

        tick();
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
